pcu_multiway: RTL
=================

# pcu_multiway

Parametrised fetch program-counter unit for the front end. It generates aligned fetch-group addresses for a configurable number of ways, with a stride of 4·WAYS bytes. Every issued request is tracked in an in-order queue of configurable depth, and each bus response is paired with its originating address and way-valid mask. On a jump, in-flight requests are squashed, so responses that return after the redirect never reach the decode stage.

## Interface
- WAYS, 2: instructions per fetch group; power of two, 1..8.
- DEPTH, 4: maximum outstanding requests; power of two, ≥2.
- RESET_PC, 32'h0000_0004: PC after reset.
- clk  in  1  sole clock; all logic on posedge.
- reset  in  1  synchronous, active-high reset.
- req_ready_i  in  1  bus accepts a request this cycle.
- req_valid_o  out  1  request offered.
- req_addr_o  out  32  group-aligned request address.
- rsp_valid_i  in  1  bus returns data for the oldest outstanding request (dataOk).
- jump_valid_i  in  1  redirect strobe.
- jump_addr_i  in  32  redirect target; bits [1:0] ignored.
- fetch_valid_o  out  1  a live response is presented to decode.
- fetch_addr_o  out  32  group address of the presented response.
- fetch_mask_o  out  WAYS  per-way valid bits of the presented response.
- err_o  out  1  sticky protocol error.

## Operation
- **Alignment.** G = 4·WAYS. req_addr_o = pc & ~(G-1). mask[i] = (req_addr_o + 4i ≥ pc).
- **Issue.** req_valid_o = !reset & (cnt < DEPTH) & !jump_valid_i.
- **Handshake.** req_valid_o & req_ready_i pushes {addr, mask, live=1} into the queue and sets pc ← req_addr_o + G, so the PC wraps modulo 2^32.
- **Response.** rsp_valid_i pops the head entry. If head.live = 1 and jump_valid_i = 0, the next cycle shows fetch_valid_o = 1 with that entry's addr and mask. Otherwise the entry is discarded silently.
- **Jump.**
  - pc ← {jump_addr_i[31:2], 2'b00}.
  - Every queued entry gets live ← 0.
  - No push happens that cycle, because req_valid_o is forced low.
- **Simultaneous push and pop.** cnt is unchanged, and both take effect.
- **Full** (cnt = DEPTH): req_valid_o = 0 and pc holds. A pop in cycle N re-enables req_valid_o in cycle N+1.
- **Empty with rsp_valid_i.** No pop, no fetch_valid_o, and err_o ← 1. err_o stays set until reset.
- **Reset mid-operation.** The queue empties, all entries are cleared, and pc ← RESET_PC. Responses for pre-reset requests are the bus's responsibility to suppress.

## Timing
- **Reset values:**
  - req_valid_o 0 (while reset is high)
  - req_addr_o = RESET_PC & ~(G-1)
  - fetch_valid_o 0
  - fetch_addr_o 0
  - fetch_mask_o 0
  - err_o 0
- **First request.** It can be offered in the first cycle after reset deasserts.
- **Request path.** req_addr_o and req_valid_o are combinational from registered pc/cnt plus jump_valid_i. There is no dependency on req_ready_i.
- **Response latency.** Exactly one cycle, rsp_valid_i to fetch_valid_o. fetch_valid_o is a single-cycle pulse per live response, and addr/mask hold their value until the next pulse.
- **Post-jump issue.** The first post-jump request is offered in the cycle after jump_valid_i.
- **Response ordering.** Responses arrive strictly in request order, at most one per cycle.

## Structure
- **pcu_pkg:**
  - `fetch_entry_t` struct {addr[31:0], mask[WAYS-1:0], live}.
  - Function `group_mask(pc, WAYS)`.
  - Constant `PC_W = 32`.
- **Sub-module `fetch_addr_queue`:**
  - Circular FIFO with wrapping read/write pointers and a count.
  - Push/pop ports, full/empty outputs.
  - A `kill` input that clears every live bit in one cycle.
- **Top level** holds pc, the issue logic, the output register and err_o.

## Test plan
All scenarios use WAYS=2, DEPTH=4, RESET_PC=0x4.

- **Streaming.** Reset, then req_ready_i=1 with rsp_valid_i one cycle after each handshake → requests 0x0/mask 10, 0x8/11, 0x10/11. fetch_valid_o shows the same sequence one cycle after each response.
- **Full.** req_ready_i=1, no responses → four handshakes (0x0, 0x8, 0x10, 0x18), then req_valid_o=0 and req_addr_o holds 0x20. One rsp_valid_i → fetch 0x0/10, and req_valid_o=1 again the next cycle.
- **Jump squash.** Three requests in flight, then jump_valid_i with target 0x106 → req_valid_o=0 that cycle, next request 0x100/mask 10. The three returning responses give no fetch_valid_o; the fourth gives 0x100/10.
- **Simultaneous events.** Jump, rsp_valid_i and req_ready_i all in the same cycle → no push, the head pops with no fetch_valid_o, and the queue's remaining entries become dead.
- **Errors and reset.** rsp_valid_i with an empty queue → err_o=1, held until reset. Reset asserted with two requests in flight → cnt=0, req_addr_o=0x0, and err_o clears.

Source files
------------

// File: rtl/pcu_pkg.sv
// Shared types and helpers for the fetch program-counter unit.
package pcu_pkg;

    localparam int PC_W     = 32;
    localparam int MAX_WAYS = 8;

    // One tracked fetch request; mask is sized for the widest supported group.
    typedef struct packed {
        logic [PC_W-1:0]     addr;
        logic [MAX_WAYS-1:0] mask;
        logic                live;
    } fetch_entry_t;

    // Per-way valid bits: a way is valid when its address is at or past pc.
    function automatic logic [MAX_WAYS-1:0] group_mask(input logic [PC_W-1:0] pc,
                                                        input int              ways);
        logic [PC_W-1:0]     base;
        logic [MAX_WAYS-1:0] m;
        base = pc & ~(PC_W'(4 * ways) - PC_W'(1));
        m    = '0;
        for (int i = 0; i < MAX_WAYS; i++) begin
            if (i < ways) m[i] = (base + PC_W'(4 * i)) >= pc;
        end
        return m;
    endfunction

endpackage

// File: rtl/pcu_multiway_fetch_addr_queue.sv
// In-order tracker of outstanding fetch requests with a one-cycle squash.
module fetch_addr_queue
    import pcu_pkg::*;
#(
    parameter  int DEPTH = 4,
    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int CNT_W = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  fetch_entry_t     push_data,
    input  logic             pop,
    input  logic             kill,
    output fetch_entry_t     head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    fetch_entry_t     mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;
    assign head    = mem[rd_ptr];

    // Storage, pointers and occupancy; kill clears live bits before a same-cycle write.
    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else begin
            if (kill) begin
                for (int i = 0; i < DEPTH; i++) mem[i].live <= 1'b0;
            end
            if (do_push) begin
                mem[wr_ptr] <= push_data;
                wr_ptr      <= wr_ptr + 1'b1;
            end
            if (do_pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

endmodule

// File: rtl/pcu_multiway.sv
// Fetch PC unit: aligned group requests, in-order response pairing, jump squash.
module pcu_multiway
    import pcu_pkg::*;
#(
    parameter int          WAYS     = 2,
    parameter int          DEPTH    = 4,
    parameter logic [31:0] RESET_PC = 32'h0000_0004
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            req_ready_i,
    output logic            req_valid_o,
    output logic [31:0]     req_addr_o,
    input  logic            rsp_valid_i,
    input  logic            jump_valid_i,
    input  logic [31:0]     jump_addr_i,
    output logic            fetch_valid_o,
    output logic [31:0]     fetch_addr_o,
    output logic [WAYS-1:0] fetch_mask_o,
    output logic            err_o
);

    localparam logic [31:0] GROUP = 32'(4 * WAYS);
    localparam int          CNT_W = $clog2(DEPTH + 1);

    logic [31:0]      pc;
    fetch_entry_t     push_entry;
    fetch_entry_t     head;
    logic             full;
    logic             empty;
    logic [CNT_W-1:0] cnt;
    logic             push;
    logic             pop;

    assign req_addr_o  = pc & ~(GROUP - 32'd1);
    assign req_valid_o = ~reset & ~full & ~jump_valid_i;
    assign push        = req_valid_o & req_ready_i;
    assign pop         = rsp_valid_i & ~empty;

    // Entry recorded for the request currently on offer.
    always_comb begin
        push_entry      = '0;
        push_entry.addr = req_addr_o;
        push_entry.mask = group_mask(pc, WAYS);
        push_entry.live = 1'b1;
    end

    fetch_addr_queue #(.DEPTH(DEPTH)) u_queue (
        .clk       (clk),
        .reset     (reset),
        .push      (push),
        .push_data (push_entry),
        .pop       (pop),
        .kill      (jump_valid_i),
        .head      (head),
        .full      (full),
        .empty     (empty),
        .count     (cnt)
    );

    // PC: redirect wins; otherwise advance one group per accepted request.
    always_ff @(posedge clk) begin
        if (reset)             pc <= RESET_PC;
        else if (jump_valid_i) pc <= {jump_addr_i[31:2], 2'b00};
        else if (push)         pc <= req_addr_o + GROUP;
    end

    // Decode-facing register: one-cycle pulse, address/mask held between pulses.
    always_ff @(posedge clk) begin
        if (reset) begin
            fetch_valid_o <= 1'b0;
            fetch_addr_o  <= '0;
            fetch_mask_o  <= '0;
        end else begin
            fetch_valid_o <= pop & head.live & ~jump_valid_i;
            if (pop & head.live & ~jump_valid_i) begin
                fetch_addr_o <= head.addr;
                fetch_mask_o <= head.mask[WAYS-1:0];
            end
        end
    end

    // Sticky error for a response with nothing outstanding.
    always_ff @(posedge clk) begin
        if (reset)                     err_o <= 1'b0;
        else if (rsp_valid_i && empty) err_o <= 1'b1;
    end

    wire unused_bits = ^{jump_addr_i[1:0], head.mask, cnt};

endmodule
